// File: rtl/clairisc_pkg.sv
// Shared constants and types for clairisc pipeline stage registers.
package clairisc_pkg;

  // Payload widths of the inter-stage registers.
  localparam int PL_FD_W = 64;   // fetch/decode: pc + instr
  localparam int PL_DE_W = 112;  // decode/execute
  localparam int PL_EW_W = 72;   // execute/writeback

  localparam int STALL_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } flow_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry holding register with load, drain and synchronous clear.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
    end else if (drain_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush, stall and stall counter.
// Define PIPE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg import clairisc_pkg::*; #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter int             CNT_W   = STALL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cls,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             vld_q, vld_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv;

  assign adv = !cls && (!vld_q || out_ready);

`ifdef PIPE_SKID_EN
  logic         in_xfer;
  logic         sk_vld;
  logic [W-1:0] sk_data;

  assign in_xfer = in_valid && in_ready;

  // Anything accepted while the main register cannot advance parks in the skid.
  pipe_skid_buf #(.W(W)) u_skid (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clr),
    .load_i  (in_xfer && !adv),
    .drain_i (adv && sk_vld),
    .data_i  (in_data),
    .vld_o   (sk_vld),
    .data_o  (sk_data)
  );

  // Depends only on state registers (and reset), never on this cycle's cls/clr/out_ready.
  assign in_ready = rst_n && !sk_vld;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (clr) begin
      vld_d  = 1'b0;
      data_d = RST_VAL;
    end else if (adv) begin
      if (sk_vld) begin
        vld_d  = 1'b1;
        data_d = sk_data;
      end else begin
        vld_d = in_xfer;
        if (in_xfer) data_d = in_data;
      end
    end
  end
`else
  assign in_ready = rst_n && !clr && adv;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (clr) begin
      vld_d  = 1'b0;
      data_d = RST_VAL;
    end else if (adv) begin
      vld_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (vld_q && (cls || !out_ready) && !clr && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign stall_cnt = cnt_q;

endmodule
